i2c_txn_arbiter: RTL
====================

I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, max cycles to wait for ctrl_done.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, N_REQ, per-requester transaction request (level).
REQ-006 SHALL have port req_slave_addr, input, N_REQ*7, packed 7-bit slave address per requester.
REQ-007 SHALL have port req_rw, input, N_REQ, 1=read, 0=write per requester.
REQ-008 SHALL have port req_mem_addr, input, N_REQ*8, packed memory address per requester.
REQ-009 SHALL have port req_wdata, input, N_REQ*8, packed write byte per requester.
REQ-010 SHALL have port gnt, output, N_REQ, one-hot grant, held for whole transaction.
REQ-011 SHALL have port done, output, N_REQ, one-cycle completion pulse to granted requester.
REQ-012 SHALL have port err, output, N_REQ, one-cycle error pulse, coincident with done.
REQ-013 SHALL have port rdata, output, 8, read byte, valid in done cycle.
REQ-014 SHALL have ports Master_en (1), Slave_Addr (7), R_W_en (1), Mem_Addr (8), Wdata (8), outputs to I2C controller.
REQ-015 SHALL have ports ctrl_done (1), ctrl_nack (1), ctrl_rdata (8), inputs from I2C controller.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ARB, LAUNCH, WAIT, FINISH.
REQ-018 IDLE: if any req bit set, go to ARB next cycle; else stay.
REQ-019 ARB: select round-robin winner starting from index (last_winner+1) mod N_REQ; assert gnt[winner]; latch its slave addr, rw, mem addr, wdata; go to LAUNCH.
REQ-020 ARB with all req deasserted (withdrawn) SHALL return to IDLE with gnt all zero.
REQ-021 LAUNCH: assert Master_en for exactly one cycle with latched fields stable on Slave_Addr/R_W_en/Mem_Addr/Wdata; go to WAIT; clear timeout counter.
REQ-022 Slave_Addr/R_W_en/Mem_Addr/Wdata SHALL stay stable from LAUNCH until FINISH exits.
REQ-023 WAIT: on ctrl_done, capture ctrl_rdata and ctrl_nack, go to FINISH; else increment counter.
REQ-024 WAIT: counter reaching TIMEOUT without ctrl_done SHALL go to FINISH with error flagged.
REQ-025 ctrl_done and timeout in same cycle: ctrl_done wins, error only from ctrl_nack.
REQ-026 FINISH: pulse done[winner], err[winner] if nack or timeout, drive rdata (0 on write or error); update last_winner; drop gnt; go to IDLE.
REQ-027 Request-to-Master_en latency SHALL be 3 cycles from IDLE (IDLE, ARB, LAUNCH); done SHALL follow ctrl_done by 1 cycle.
REQ-028 Changes to req inputs after ARB SHALL NOT affect the in-flight transaction; requester deasserting req mid-transaction still receives done.
REQ-029 Round-robin pointer SHALL wrap from N_REQ-1 to 0; no requester starves with continuous requests.
REQ-030 ctrl_done outside WAIT SHALL be ignored.
REQ-031 Back-to-back: requester holding req after done SHALL be re-eligible in the next ARB but at lowest priority.

Reset
REQ-032 On reset: state IDLE, gnt/done/err=0, Master_en=0, Slave_Addr/Mem_Addr/Wdata/rdata=0, R_W_en=0, busy=0, counter=0, last_winner=N_REQ-1 (so requester 0 wins first).
REQ-033 Reset asserted mid-transaction SHALL abort immediately with no done/err pulse.

Structure
REQ-034 Shared package i2c_pkg SHALL hold the FSM state enum, SLAVE_ADDR_W=7, MEM_ADDR_W=8, DATA_W=8.
REQ-035 Round-robin selection SHALL be sub-module rr_picker (req vector + last_winner -> one-hot grant, valid).

Verification
REQ-036 Single req[0], slave 7'h55, write, mem 8'h00, wdata 8'hAA; ctrl_done after 20 cycles -> Master_en 3 cycles after req, done[0] pulse, err[0]=0, rdata=0.
REQ-037 req[2] read, ctrl_rdata=8'h5A with ctrl_done -> done[2] and rdata=8'h5A in the same cycle.
REQ-038 req=4'b1111 held through 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-039 ctrl_done never asserted -> after 1023 WAIT cycles done and err pulse for granted requester, busy drops next cycle.
REQ-040 ctrl_nack=1 with ctrl_done on write -> err pulse with done, rdata=0; reset asserted in WAIT -> all outputs zero same cycle, no done.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared FSM state type and field widths for the I2C transaction arbiter.
package i2c_pkg;

  localparam int SLAVE_ADDR_W = 7;
  localparam int MEM_ADDR_W   = 8;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: the first requester after last_i (wrapping) wins.
// The request vector is rotated so the search starts at bit 0, then the winner is rotated back.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [IDX_W:0]     sh_s;
  logic [N_REQ-1:0]   rot_s;
  logic [N_REQ-1:0]   first_s;
  logic [2*N_REQ-1:0] oh_s;

  // Rotate, isolate the lowest set bit, rotate back.
  always_comb begin
    sh_s    = {1'b0, last_i} + {{IDX_W{1'b0}}, 1'b1};
    rot_s   = N_REQ'({req_i, req_i} >> sh_s);
    first_s = rot_s & ~(rot_s - {{(N_REQ-1){1'b0}}, 1'b1});
    oh_s    = {{N_REQ{1'b0}}, first_s} << sh_s;
    gnt_o   = oh_s[N_REQ-1:0] | oh_s[2*N_REQ-1:N_REQ];
    valid_o = |req_i;
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates N_REQ requesters onto one I2C controller, one transaction at a time,
// with round-robin fairness and a bounded wait for the controller to finish.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*SLAVE_ADDR_W-1:0] req_slave_addr,
  input  logic [N_REQ-1:0]              req_rw,
  input  logic [N_REQ*MEM_ADDR_W-1:0]   req_mem_addr,
  input  logic [N_REQ*DATA_W-1:0]       req_wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [N_REQ-1:0]              err,
  output logic [DATA_W-1:0]             rdata,
  output logic                          Master_en,
  output logic [SLAVE_ADDR_W-1:0]       Slave_Addr,
  output logic                          R_W_en,
  output logic [MEM_ADDR_W-1:0]         Mem_Addr,
  output logic [DATA_W-1:0]             Wdata,
  input  logic                          ctrl_done,
  input  logic                          ctrl_nack,
  input  logic [DATA_W-1:0]             ctrl_rdata,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t              state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    master_en_q, master_en_d;
  logic                    busy_q, busy_d;
  logic [SLAVE_ADDR_W-1:0] slave_addr_q, slave_addr_d;
  logic                    rw_q, rw_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        last_q, last_d;

  logic [N_REQ-1:0]        pick_gnt_s;
  logic                    pick_valid_s;
  logic [IDX_W-1:0]        gnt_idx_s;
  logic [SLAVE_ADDR_W-1:0] sel_sa_s;
  logic                    sel_rw_s;
  logic [MEM_ADDR_W-1:0]   sel_ma_s;
  logic [DATA_W-1:0]       sel_wd_s;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt_s),
    .valid_o (pick_valid_s)
  );

  // One-hot muxes: fields of the picked requester, and index of the current grant.
  always_comb begin
    sel_sa_s  = '0;
    sel_rw_s  = 1'b0;
    sel_ma_s  = '0;
    sel_wd_s  = '0;
    gnt_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_sa_s  = sel_sa_s | (pick_gnt_s[i] ? req_slave_addr[i*SLAVE_ADDR_W +: SLAVE_ADDR_W] : '0);
      sel_rw_s  = sel_rw_s | (pick_gnt_s[i] & req_rw[i]);
      sel_ma_s  = sel_ma_s | (pick_gnt_s[i] ? req_mem_addr[i*MEM_ADDR_W +: MEM_ADDR_W] : '0);
      sel_wd_s  = sel_wd_s | (pick_gnt_s[i] ? req_wdata[i*DATA_W +: DATA_W] : '0);
      gnt_idx_s = gnt_idx_s | (gnt_q[i] ? IDX_W'(i) : '0);
    end
  end

  // Next-state and registered-output logic; done/err/rdata are one-cycle values for FINISH.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = '0;
    rdata_d      = '0;
    master_en_d  = 1'b0;
    slave_addr_d = slave_addr_q;
    rw_d         = rw_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (pick_valid_s) begin
          gnt_d        = pick_gnt_s;
          slave_addr_d = sel_sa_s;
          rw_d         = sel_rw_s;
          mem_addr_d   = sel_ma_s;
          wdata_d      = sel_wd_s;
          master_en_d  = 1'b1;
          state_d      = LAUNCH;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the final counted cycle still beats the timeout.
        if (ctrl_done) begin
          done_d  = gnt_q;
          err_d   = ctrl_nack ? gnt_q : '0;
          rdata_d = (rw_q && !ctrl_nack) ? ctrl_rdata : '0;
          state_d = FINISH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        last_d  = gnt_idx_s;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction without a completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      master_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      slave_addr_q <= '0;
      rw_q         <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      master_en_q  <= master_en_d;
      busy_q       <= busy_d;
      slave_addr_q <= slave_addr_d;
      rw_q         <= rw_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign Master_en  = master_en_q;
  assign busy       = busy_q;
  assign Slave_Addr = slave_addr_q;
  assign R_W_en     = rw_q;
  assign Mem_Addr   = mem_addr_q;
  assign Wdata      = wdata_q;

endmodule
